jtframe_sdram_rr_arb: RTL and testbench

Four-port arbiter that shares one SDRAM bank controller between up to four slot managers (each a jtframe_ram1_4slots-style requester presenting rd/wr/addr/data and waiting for ack and data_rdy). Selects one requester at a time by rotating priority, with optional fixed priority for port 0 bounded by a starvation limit. Latches the winner's request, drives the controller, and routes ack/dst/rdy back to the owner only. Sits between the per-bank slot managers and the SDRAM controller bank port.

---
 rtl/jtframe_sdram_arb_pkg.sv | 23 ++
 rtl/jtframe_rr_pick.sv | 33 +++
 rtl/jtframe_sdram_rr_arb.sv | 140 ++++++++++++++
 tb/tb_jtframe_sdram_rr_arb.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_sdram_arb_pkg.sv
// Shared definitions for the four-port SDRAM bank arbiter.
// Covers the state encoding, the port count and owner width, and a one-hot decoder.
package jtframe_sdram_arb_pkg;

    localparam int NPORTS = 4;
    localparam int OWNW   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    function automatic logic [OWNW-1:0] oh2idx(input logic [NPORTS-1:0] oh);
        logic [OWNW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (oh[i]) idx = OWNW'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/jtframe_rr_pick.sv
// Combinational 4-way rotating-priority picker.
// The search starts one past the pointer and ends on the pointer itself.
module jtframe_rr_pick
    import jtframe_sdram_arb_pkg::*;
(
    input  logic [NPORTS-1:0] pending_i,
    input  logic [NPORTS-1:0] mask_i,
    input  logic [OWNW-1:0]   ptr_i,
    output logic [NPORTS-1:0] grant_o,
    output logic              valid_o
);

    logic [NPORTS-1:0] eff;
    logic [OWNW-1:0]   idx;
    logic              found;

    always_comb begin
        eff     = pending_i & ~mask_i;
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        // k == NPORTS wraps back onto the pointer, so the last owner is tried last.
        for (int k = 1; k <= NPORTS; k++) begin
            idx = ptr_i + OWNW'(k);
            if (!found && eff[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/jtframe_sdram_rr_arb.sv
// Shares one SDRAM bank port between four slot managers, using rotating priority.
// Port 0 can optionally take fixed priority; a starvation limit bounds how long it can hold the bank.
module jtframe_sdram_rr_arb
    import jtframe_sdram_arb_pkg::*;
#(
    parameter int SDRAMW = 22,
    parameter bit PRIO0  = 1'b1,
    parameter int STARVE = 15
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            req_rd,
    input  logic [3:0]            req_wr,
    input  logic [4*SDRAMW-1:0]   req_addr,
    input  logic [63:0]           req_din,
    input  logic [7:0]            req_wrmask,
    output logic [3:0]            req_ack,
    output logic [3:0]            req_dst,
    output logic [3:0]            req_rdy,
    output logic [1:0]            owner,
    output logic                  busy,
    output logic                  sdram_rd,
    output logic                  sdram_wr,
    output logic [SDRAMW-1:0]     sdram_addr,
    output logic [15:0]           data_write,
    output logic [1:0]            sdram_wrmask,
    input  logic                  sdram_ack,
    input  logic                  data_dst,
    input  logic                  data_rdy,
    output arb_state_e            dbg_state_o
);

    localparam logic [3:0] STARVE_W = 4'(STARVE);

    arb_state_e        state_q;
    logic [OWNW-1:0]   owner_q;
    logic              rd_q, wr_q;
    logic [SDRAMW-1:0] addr_q;
    logic [15:0]       dout_q;
    logic [1:0]        mask_q;
    logic [3:0]        starve_q, starve_d;

    logic [3:0]        pend, own_mask, rr_mask, rr_gnt, win_oh;
    logic              rr_vld, win_vld, starved, oth_pend, arb_now, win_wr;
    logic [OWNW-1:0]   win_idx;

    always_comb begin
        pend     = req_rd | req_wr;
        oth_pend = |pend[3:1];
        starved  = (starve_q == STARVE_W) && oth_pend;
        own_mask = (state_q == ST_DATA) ? (4'b0001 << owner_q) : 4'b0000;
        rr_mask  = own_mask | ((PRIO0 && starved) ? 4'b0001 : 4'b0000);
    end

    jtframe_rr_pick u_pick (
        .pending_i (pend),
        .mask_i    (rr_mask),
        .ptr_i     (owner_q),
        .grant_o   (rr_gnt),
        .valid_o   (rr_vld)
    );

    // Port 0 priority looks at raw pending, so a port 0 that keeps requesting is re-granted back to back.
    always_comb begin
        if (PRIO0 && pend[0] && !starved) begin
            win_oh  = 4'b0001;
            win_vld = 1'b1;
        end else begin
            win_oh  = rr_gnt;
            win_vld = rr_vld;
        end
        win_idx = oh2idx(win_oh);
        win_wr  = req_wr[win_idx];
        arb_now = (state_q == ST_DATA) ? data_rdy : (state_q != ST_REQ);

        starve_d = starve_q;
        if (!oth_pend) begin
            starve_d = 4'd0;
        end else if (arb_now && win_vld) begin
            if (win_idx == 2'd0)
                starve_d = (starve_q == STARVE_W) ? starve_q : starve_q + 4'd1;
            else
                starve_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= 2'd3;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            dout_q   <= '0;
            mask_q   <= 2'b11;
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
            case (state_q)
                ST_REQ: begin
                    if (sdram_ack) begin
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        state_q <= ST_DATA;
                    end
                end
                default: begin
                    if (arb_now) begin
                        if (win_vld) begin
                            owner_q <= win_idx;
                            rd_q    <= !win_wr;
                            wr_q    <= win_wr;
                            addr_q  <= req_addr[win_idx*SDRAMW +: SDRAMW];
                            dout_q  <= req_din[win_idx*16 +: 16];
                            mask_q  <= win_wr ? req_wrmask[win_idx*2 +: 2] : 2'b11;
                            state_q <= ST_REQ;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // Controller strobes reach only the current owner, and only in the state that expects them.
    assign req_ack = (sdram_ack && state_q == ST_REQ)  ? (4'b0001 << owner_q) : 4'b0000;
    assign req_dst = (data_dst  && state_q == ST_DATA) ? (4'b0001 << owner_q) : 4'b0000;
    assign req_rdy = (data_rdy  && state_q == ST_DATA) ? (4'b0001 << owner_q) : 4'b0000;

    assign owner        = owner_q;
    assign busy         = (state_q != ST_IDLE);
    assign sdram_rd     = rd_q;
    assign sdram_wr     = wr_q;
    assign sdram_addr   = addr_q;
    assign data_write   = dout_q;
    assign sdram_wrmask = mask_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_jtframe_sdram_rr_arb.sv
// Directed bench for the SDRAM arbiter: one instance runs pure round-robin, the other runs with port-0 priority.
// A grant scoreboard checks every transaction.
module tb_jtframe_sdram_rr_arb;
  import jtframe_sdram_arb_pkg::*;

  localparam int AW = 22;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [3:0]     rd, wr;
  logic [4*AW-1:0] addr;
  logic [63:0]    din;
  logic [7:0]     wmask;
  logic           ack, dst, rdy;

  logic [3:0]     a_ack, a_dst, a_rdy, b_ack, b_dst, b_rdy;
  logic [1:0]     a_owner, b_owner, a_mask, b_mask;
  logic           a_busy, b_busy, a_rd, b_rd, a_wr, b_wr;
  logic [AW-1:0]  a_addr, b_addr;
  logic [15:0]    a_dw, b_dw;
  arb_state_e     a_st, b_st;

  jtframe_sdram_rr_arb #(.SDRAMW(AW), .PRIO0(1'b0), .STARVE(15)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_rd(rd), .req_wr(wr), .req_addr(addr),
    .req_din(din), .req_wrmask(wmask), .req_ack(a_ack), .req_dst(a_dst),
    .req_rdy(a_rdy), .owner(a_owner), .busy(a_busy), .sdram_rd(a_rd),
    .sdram_wr(a_wr), .sdram_addr(a_addr), .data_write(a_dw),
    .sdram_wrmask(a_mask), .sdram_ack(ack), .data_dst(dst), .data_rdy(rdy),
    .dbg_state_o(a_st)
  );

  jtframe_sdram_rr_arb #(.SDRAMW(AW), .PRIO0(1'b1), .STARVE(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_rd(rd), .req_wr(wr), .req_addr(addr),
    .req_din(din), .req_wrmask(wmask), .req_ack(b_ack), .req_dst(b_dst),
    .req_rdy(b_rdy), .owner(b_owner), .busy(b_busy), .sdram_rd(b_rd),
    .sdram_wr(b_wr), .sdram_addr(b_addr), .data_write(b_dw),
    .sdram_wrmask(b_mask), .sdram_ack(ack), .data_dst(dst), .data_rdy(rdy),
    .dbg_state_o(b_st)
  );

  // Observation mux: sel_b picks which instance is under check.
  logic           sel_b;
  logic [3:0]     o_ack, o_dst, o_rdy;
  logic [1:0]     o_owner, o_mask;
  logic           o_busy, o_rd, o_wr;
  logic [AW-1:0]  o_addr;
  logic [15:0]    o_dw;
  arb_state_e     o_st;

  always_comb begin
    o_ack   = sel_b ? b_ack   : a_ack;
    o_dst   = sel_b ? b_dst   : a_dst;
    o_rdy   = sel_b ? b_rdy   : a_rdy;
    o_owner = sel_b ? b_owner : a_owner;
    o_mask  = sel_b ? b_mask  : a_mask;
    o_busy  = sel_b ? b_busy  : a_busy;
    o_rd    = sel_b ? b_rd    : a_rd;
    o_wr    = sel_b ? b_wr    : a_wr;
    o_addr  = sel_b ? b_addr  : a_addr;
    o_dw    = sel_b ? b_dw    : a_dw;
    o_st    = sel_b ? b_st    : a_st;
  end

  int n_vec = 0;
  int n_err = 0;

  // Entry layout: {wr, mask[1:0], din[15:0], addr[AW-1:0], port[1:0]}
  logic [42:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [42:0] mk_exp(input logic [1:0] p);
    logic        w;
    logic [1:0]  m;
    w = wr[p];
    m = w ? wmask[p*2 +: 2] : 2'b11;
    return {w, m, din[p*16 +: 16], addr[p*AW +: AW], p};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    rd = '0; wr = '0; addr = '0; din = '0; wmask = '1;
    ack = 1'b0; dst = 1'b0; rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One controller transaction. It checks the issued request, acks it, then completes it.
  task automatic ctrl_txn(input bit release_req, input bit clr_all);
    logic [42:0] e;
    logic [1:0]  p;
    @(negedge clk);
    rdy = 1'b0;
    dst = 1'b0;
    if (exp_q.size() == 0) begin
      chk("scoreboard_underflow", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    p = e[1:0];
    chk("req_issued", {30'd0, o_rd, o_wr}, e[42] ? 32'd1 : 32'd2);
    chk("owner", {30'd0, o_owner}, {30'd0, p});
    chk("sdram_addr", {10'd0, o_addr}, {10'd0, e[23:2]});
    chk("sdram_wrmask", {30'd0, o_mask}, {30'd0, e[41:40]});
    if (e[42]) chk("data_write", {16'd0, o_dw}, {16'd0, e[39:24]});
    ack = 1'b1;
    #1;
    chk("req_ack", {28'd0, o_ack}, 32'd1 << p);
    @(negedge clk);
    ack = 1'b0;
    chk("req_dropped", {30'd0, o_rd, o_wr}, 32'd0);
    if (release_req) begin
      rd[p] = 1'b0;
      wr[p] = 1'b0;
    end
    if (clr_all) begin
      rd = '0;
      wr = '0;
    end
    dst = 1'b1;
    rdy = 1'b1;
    #1;
    chk("req_dst", {28'd0, o_dst}, 32'd1 << p);
    chk("req_rdy", {28'd0, o_rdy}, 32'd1 << p);
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    rdy = 1'b0;
    dst = 1'b0;
    chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    chk({tag, "_state"}, 32'(o_st), 32'(ST_IDLE));
    chk({tag, "_rdwr"}, {30'd0, o_rd, o_wr}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sel_b = 1'b0;
    do_reset();

    chk("rst_owner", {30'd0, o_owner}, 32'd3);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_rdwr", {30'd0, o_rd, o_wr}, 32'd0);
    chk("rst_addr", {10'd0, o_addr}, 32'd0);
    chk("rst_dw", {16'd0, o_dw}, 32'd0);
    chk("rst_mask", {30'd0, o_mask}, 32'd3);
    chk("rst_ack", {28'd0, o_ack}, 32'd0);

    // Single read on port 2
    addr[2*AW +: AW] = 22'h1234;
    rd[2] = 1'b1;
    exp_q.push_back(mk_exp(2'd2));
    ctrl_txn(1'b1, 1'b0);
    idle_chk("single_rd_done");

    // Round-robin with all four ports holding reads
    do_reset();
    for (int i = 0; i < 4; i++) addr[i*AW +: AW] = AW'(22'h100 + i);
    rd = 4'hF;
    exp_q.push_back(mk_exp(2'd0));
    exp_q.push_back(mk_exp(2'd1));
    exp_q.push_back(mk_exp(2'd2));
    exp_q.push_back(mk_exp(2'd3));
    exp_q.push_back(mk_exp(2'd0));
    for (int k = 0; k < 5; k++) ctrl_txn(1'b0, k == 4);
    idle_chk("rr_done");

    // Write on port 1 with the read also raised; the write wins
    do_reset();
    addr[1*AW +: AW] = 22'h2AA;
    din[16 +: 16] = 16'hBEEF;
    wmask[2 +: 2] = 2'b01;
    rd[1] = 1'b1;
    wr[1] = 1'b1;
    exp_q.push_back(mk_exp(2'd1));
    ctrl_txn(1'b1, 1'b0);
    idle_chk("wr_done");
    rd[1] = 1'b1;
    exp_q.push_back(mk_exp(2'd1));
    ctrl_txn(1'b1, 1'b0);
    idle_chk("rd_after_wr_done");

    // Controller strobes while idle are ignored
    ack = 1'b1; dst = 1'b1; rdy = 1'b1;
    #1;
    chk("idle_req_ack", {28'd0, o_ack}, 32'd0);
    chk("idle_req_dst", {28'd0, o_dst}, 32'd0);
    chk("idle_req_rdy", {28'd0, o_rdy}, 32'd0);
    @(negedge clk);
    ack = 1'b0;
    idle_chk("idle_pulse");

    // Port-0 priority with starvation limit 3
    sel_b = 1'b1;
    do_reset();
    addr[0*AW +: AW] = 22'h0A0;
    addr[3*AW +: AW] = 22'h3A3;
    rd[0] = 1'b1;
    rd[3] = 1'b1;
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(mk_exp(2'd0));
      exp_q.push_back(mk_exp(2'd0));
      exp_q.push_back(mk_exp(2'd0));
      exp_q.push_back(mk_exp(2'd3));
    end
    for (int k = 0; k < 8; k++) ctrl_txn(1'b0, k == 7);
    idle_chk("prio_done");

    // Reset while in DATA with owner 2
    sel_b = 1'b0;
    do_reset();
    addr[2*AW +: AW] = 22'h0777;
    rd[2] = 1'b1;
    @(negedge clk);
    chk("mid_rd", {31'd0, o_rd}, 32'd1);
    chk("mid_owner", {30'd0, o_owner}, 32'd2);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("mid_state", 32'(o_st), 32'(ST_DATA));
    rd = '0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
    chk("mid_rst_rd", {31'd0, o_rd}, 32'd0);
    chk("mid_rst_owner", {30'd0, o_owner}, 32'd3);
    chk("mid_rst_addr", {10'd0, o_addr}, 32'd0);
    chk("mid_rst_mask", {30'd0, o_mask}, 32'd3);
    rst_n = 1'b1;
    dst = 1'b1;
    rdy = 1'b1;
    #1;
    chk("mid_late_rdy", {28'd0, o_rdy}, 32'd0);
    chk("mid_late_dst", {28'd0, o_dst}, 32'd0);
    idle_chk("mid_after");

    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
